// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: channel modes and lock FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_RUN      = 2'd2
  } lock_state_e;

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises the PLL lock flag and only reports run once it has stayed high for LOCK_HOLD
// clocks; any low sample drops straight back to UNLOCKED.
module lock_qualifier
  import led_pkg::*;
#(
  parameter int unsigned LOCK_HOLD = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  output logic run_o
);

  localparam int unsigned HoldW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LOCK_HOLD - 1);

  logic             s1_q, s2_q;
  lock_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_UNLOCKED: begin
        hold_cnt_d = '0;
        if (s2_q) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!s2_q) begin
          state_d    = ST_UNLOCKED;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldMax) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!s2_q) state_d = ST_UNLOCKED;
      end
      default: begin
        state_d    = ST_UNLOCKED;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= ST_UNLOCKED;
      hold_cnt_q <= '0;
    end else begin
      s1_q       <= locked_i;
      s2_q       <= s1_q;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign run_o = (state_q == ST_RUN);

endmodule

// File: rtl/led_lock_pattern_gen.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/PWM per channel), with every output gated
// by the qualified PLL lock.
module led_lock_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned LOCK_HOLD = 1024,
  parameter int unsigned CH_W      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                locked_i,
  input  logic                wr_en_i,
  input  logic [CH_W-1:0]     wr_ch_i,
  input  logic [1:0]          wr_mode_i,
  input  logic [PWM_W-1:0]    wr_duty_i,
  output logic                run_o,
  output logic [CHANNELS-1:0] led_o
);

  logic             run;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  lock_qualifier #(
    .LOCK_HOLD(LOCK_HOLD)
  ) u_lock (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .locked_i(locked_i),
    .run_o   (run)
  );

  // Counters sit at zero outside RUN so every lock-up restarts the patterns from phase 0.
  always_comb begin
    cnt_d     = '0;
    pwm_cnt_d = '0;
    if (run) begin
      cnt_d     = cnt_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_mode_e        mode_q, mode_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             led_q, led_d;

    // Indices at or above CHANNELS never match any channel, so such writes drop silently.
    always_comb begin
      mode_d = mode_q;
      duty_d = duty_q;
      if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
        mode_d = led_mode_e'(wr_mode_i);
        duty_d = wr_duty_i;
      end
    end

    always_comb begin
      led_d = 1'b0;
      if (run) begin
        unique case (mode_q)
          MODE_OFF:   led_d = 1'b0;
          MODE_ON:    led_d = 1'b1;
          MODE_BLINK: led_d = cnt_q[CNT_W-1];
          MODE_PWM:   led_d = (pwm_cnt_q < duty_q);
          default:    led_d = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mode_q <= MODE_OFF;
        duty_q <= '0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_d;
        duty_q <= duty_d;
        led_q  <= led_d;
      end
    end

    assign led_o[i] = led_q;
  end

  assign run_o = run;

endmodule

// File: tb/tb_led_lock_pattern_gen.sv
// Directed bench for led_lock_pattern_gen with CHANNELS=2, CNT_W=4, PWM_W=3, LOCK_HOLD=4.
module tb_led_lock_pattern_gen;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       wr_en;
  logic [3:0] wr_ch;
  logic [1:0] wr_mode;
  logic [2:0] wr_duty;
  logic       run;
  logic [1:0] led;

  int n_vec = 0;
  int n_err = 0;
  int ed    = 0;  // edges counted from the last locked rise (or drop)

  always #5 clk = ~clk;

  led_lock_pattern_gen #(
    .CHANNELS (2),
    .CNT_W    (4),
    .PWM_W    (3),
    .LOCK_HOLD(4),
    .CH_W     (4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .locked_i (locked),
    .wr_en_i  (wr_en),
    .wr_ch_i  (wr_ch),
    .wr_mode_i(wr_mode),
    .wr_duty_i(wr_duty),
    .run_o    (run),
    .led_o    (led)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (ed=%0d t=%0t)", tag, got, exp, ed, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic wr(input logic [3:0] ch, input led_mode_e mode, input logic [2:0] duty);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_mode = mode;
    wr_duty = duty;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic reset_pulse();
    locked = 1'b0;
    rst    = 1'b1;
    #1;
    check_eq("rst_run", 32'(run), 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Checks ch1 in PWM against the counter phase and the on-count over one full period.
  task automatic pwm_window(input logic [2:0] duty);
    int hi;
    hi = 0;
    wr(4'd1, MODE_PWM, duty);
    repeat (8) begin
      step();
      check_eq("pwm_led1", 32'(led[1]), 32'(((ed - 8) % 8) < int'(duty)));
      hi += int'(led[1]);
    end
    check_eq("pwm_ontime", 32'(hi), 32'(duty));
  endtask

  initial begin
    rst     = 1'b1;
    locked  = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_mode = '0;
    wr_duty = '0;

    // 1: lock-up, run rises after edge LOCK_HOLD+3 = 7
    reset_pulse();
    locked = 1'b1;
    ed = 0;
    repeat (10) begin
      step();
      check_eq("t1_run", 32'(run), 32'(ed >= 7));
      check_eq("t1_led", 32'(led), 32'd0);
    end

    // 2: one-cycle glitch during HOLD; second rise before edge 5, so run after edge 11
    reset_pulse();
    locked = 1'b1;
    ed = 0;
    repeat (3) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    repeat (8) begin
      step();
      check_eq("t2_run", 32'(run), 32'(ed >= 11));
    end

    // 3: BLINK on ch0 written at the first RUN edge; counter before edge k is k-8
    reset_pulse();
    locked = 1'b1;
    ed = 0;
    repeat (7) step();
    check_eq("t3_run", 32'(run), 32'd1);
    wr(4'd0, MODE_BLINK, 3'd0);
    check_eq("t3_led0_first", 32'(led[0]), 32'd0);
    while (ed < 40) begin
      step();
      check_eq("t3_led0", 32'(led[0]), 32'(((ed - 8) % 16) >= 8));
      check_eq("t3_led1", 32'(led[1]), 32'd0);
    end

    // 4: PWM duties 3, 0 and 7 on ch1
    pwm_window(3'd3);
    pwm_window(3'd0);
    pwm_window(3'd7);

    // 5: lock loss with ch0 ON, then re-lock without rewriting ch0
    wr(4'd0, MODE_ON, 3'd0);
    step();
    check_eq("t5_on", 32'(led[0]), 32'd1);
    locked = 1'b0;
    ed = 0;
    repeat (5) begin
      step();
      check_eq("t5_run_drop", 32'(run), 32'(ed < 3));
      check_eq("t5_led_drop", 32'(led[0]), 32'(ed < 4));
    end
    wr(4'd1, MODE_BLINK, 3'd0);  // written while UNLOCKED
    step();
    locked = 1'b1;
    ed = 0;
    repeat (24) begin
      step();
      check_eq("t5_run_relock", 32'(run), 32'(ed >= 7));
      check_eq("t5_led0_relock", 32'(led[0]), 32'(ed >= 8));
      check_eq("t5_led1_blink", 32'(led[1]), 32'((ed >= 8) && (((ed - 8) % 16) >= 8)));
    end

    // 6: out-of-range write ignored; asynchronous reset clears everything
    wr(4'd0, MODE_OFF, 3'd0);
    step();
    check_eq("t6_off", 32'(led[0]), 32'd0);
    wr(4'd2, MODE_ON, 3'd0);
    repeat (3) begin
      step();
      check_eq("t6_ch2_ignored", 32'(led[0]), 32'd0);
    end
    wr(4'd0, MODE_ON, 3'd0);
    step();
    check_eq("t6_on", 32'(led[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_run", 32'(run), 32'd0);
    check_eq("t6_rst_led", 32'(led), 32'd0);
    step();
    rst = 1'b0;
    ed = 0;
    repeat (24) begin
      step();
      check_eq("t6_run_after_rst", 32'(run), 32'(ed >= 7));
      check_eq("t6_cfg_cleared", 32'(led), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
